// File: rtl/pulse_stretcher_if.sv
// Lane bundle for pulse_stretcher: event pulses in, stretched levels and status out.
interface pulse_stretcher_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] pulse_in;
    logic [WIDTH-1:0] level_out;
    logic [WIDTH-1:0] busy;
    logic [WIDTH-1:0] overflow;

    modport master (output pulse_in, input level_out, busy, overflow);
    modport slave  (input pulse_in, output level_out, busy, overflow);
endinterface

// File: rtl/pulse_stretcher.sv
// Per-lane pulse-to-level stretcher with minimum high time, minimum low gap and a one-deep event queue.
// Define PULSE_STRETCHER_RETRIGGER_EN to let pulses during the high phase extend it instead of queueing.
module pulse_stretcher #(
    parameter int WIDTH       = 1,
    parameter int HIGH_CYCLES = 4,
    parameter int GAP_CYCLES  = 2
) (
    input logic              clk,
    input logic              async_nreset,
    pulse_stretcher_if.slave bus
);
    localparam int MAX_CYCLES = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state_q [WIDTH];
    state_t           state_d [WIDTH];
    logic [CNT_W-1:0] cnt_q   [WIDTH];
    logic [CNT_W-1:0] cnt_d   [WIDTH];
    logic [WIDTH-1:0] pending_q, pending_d;
    logic [WIDTH-1:0] level_q, level_d;
    logic [WIDTH-1:0] overflow_q, overflow_d;
    logic [WIDTH-1:0] busy;

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            pending_q  <= '0;
            level_q    <= '0;
            overflow_q <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pending_q  <= pending_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        pending_d  = pending_q;
        overflow_d = '0;
        level_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            case (state_q[i])
                IDLE: begin
                    if (bus.pulse_in[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = HIGH_LOAD;
                    end
                end
                HIGH: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end else begin
                        state_d[i] = GAP;
                        cnt_d[i]   = GAP_LOAD;
                    end
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                    if (bus.pulse_in[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = HIGH_LOAD;
                    end
`else
                    if (bus.pulse_in[i]) begin
                        if (pending_q[i]) overflow_d[i] = 1'b1;
                        else              pending_d[i]  = 1'b1;
                    end
`endif
                end
                GAP: begin
                    if (cnt_q[i] != '0) begin
                        cnt_d[i] = cnt_q[i] - 1'b1;
                        if (bus.pulse_in[i]) begin
                            if (pending_q[i]) overflow_d[i] = 1'b1;
                            else              pending_d[i]  = 1'b1;
                        end
                    end else if (pending_q[i] || bus.pulse_in[i]) begin
                        state_d[i] = HIGH;
                        cnt_d[i]   = HIGH_LOAD;
                        // Queued event launches now; a pulse arriving alongside it takes its place in the queue.
                        pending_d[i] = pending_q[i] & bus.pulse_in[i];
                    end else begin
                        state_d[i] = IDLE;
                    end
                end
                default: begin
                    state_d[i] = IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
            level_d[i] = (state_d[i] == HIGH);
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < WIDTH; i++) begin
            busy[i] = (state_q[i] != IDLE) | pending_q[i];
        end
    end

    assign bus.level_out = level_q;
    assign bus.busy      = busy;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench for pulse_stretcher (WIDTH=2, HIGH_CYCLES=3, GAP_CYCLES=2) with per-cycle expected masks.
module tb_pulse_stretcher;
    logic clk = 1'b0;
    logic async_nreset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    pulse_stretcher_if #(.WIDTH(2)) bus ();

    pulse_stretcher #(
        .WIDTH(2),
        .HIGH_CYCLES(3),
        .GAP_CYCLES(2)
    ) dut (
        .clk(clk),
        .async_nreset(async_nreset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int cyc, input logic [1:0] got, input logic [1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %b expected %b", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] rng(input int lo, input int hi);
        logic [31:0] m;
        m = '0;
        for (int k = lo; k <= hi; k++) m[k] = 1'b1;
        return m;
    endfunction

    task automatic apply_reset();
        bus.pulse_in = '0;
        async_nreset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_level", -1, bus.level_out, 2'b00);
        check("reset_busy",  -1, bus.busy,      2'b00);
        check("reset_ovf",   -1, bus.overflow,  2'b00);
        async_nreset = 1'b1;
    endtask

    // Cycle c starts at a rising edge; pulses are driven just after it, outputs checked at the falling edge.
    task automatic run_case(input string name, input int ncyc,
                            input logic [31:0] p0, input logic [31:0] p1,
                            input logic [31:0] lvl0, input logic [31:0] bsy0, input logic [31:0] ovf0,
                            input logic [31:0] lvl1, input logic [31:0] bsy1, input logic [31:0] ovf1,
                            input int rst_lo, input int rst_hi);
        apply_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            #1;
            async_nreset = !(c >= rst_lo && c <= rst_hi);
            bus.pulse_in = {p1[c], p0[c]};
            @(negedge clk);
            check({name, "_level"}, c, bus.level_out, {lvl1[c], lvl0[c]});
            check({name, "_busy"},  c, bus.busy,      {bsy1[c], bsy0[c]});
            check({name, "_ovf"},   c, bus.overflow,  {ovf1[c], ovf0[c]});
        end
        @(posedge clk);
        #1;
        bus.pulse_in = '0;
        async_nreset = 1'b1;
    endtask

    initial begin
        bus.pulse_in = '0;

        run_case("single", 24, 32'h1 << 10, '0,
                 rng(11, 13), rng(11, 15), '0,
                 '0, '0, '0, -1, -1);

`ifdef PULSE_STRETCHER_RETRIGGER_EN
        run_case("two_pulse", 24, (32'h1 << 10) | (32'h1 << 12), 32'h1 << 3,
                 rng(11, 15), rng(11, 17), '0,
                 rng(4, 6), rng(4, 8), '0, -1, -1);
        run_case("three_pulse", 26, (32'h1 << 10) | (32'h1 << 12) | (32'h1 << 14), '0,
                 rng(11, 17), rng(11, 19), '0,
                 '0, '0, '0, -1, -1);
        run_case("requeue", 30, (32'h1 << 10) | (32'h1 << 12) | (32'h1 << 15), '0,
                 rng(11, 18), rng(11, 20), '0,
                 '0, '0, '0, -1, -1);
`else
        run_case("two_pulse", 24, (32'h1 << 10) | (32'h1 << 12), 32'h1 << 3,
                 rng(11, 13) | rng(16, 18), rng(11, 20), '0,
                 rng(4, 6), rng(4, 8), '0, -1, -1);
        run_case("three_pulse", 26, (32'h1 << 10) | (32'h1 << 12) | (32'h1 << 14), '0,
                 rng(11, 13) | rng(16, 18), rng(11, 20), 32'h1 << 15,
                 '0, '0, '0, -1, -1);
        run_case("requeue", 30, (32'h1 << 10) | (32'h1 << 12) | (32'h1 << 15), '0,
                 rng(11, 13) | rng(16, 18) | rng(21, 23), rng(11, 25), '0,
                 '0, '0, '0, -1, -1);
`endif

        run_case("gap_end", 24, (32'h1 << 10) | (32'h1 << 15), '0,
                 rng(11, 13) | rng(16, 18), rng(11, 20), '0,
                 '0, '0, '0, -1, -1);

        run_case("mid_reset", 28, 32'h1 << 11, (32'h1 << 10) | (32'h1 << 20),
                 '0, '0, '0,
                 rng(11, 11) | rng(21, 23), rng(11, 11) | rng(21, 25), '0, 12, 14);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_stretcher.md
Name: pulse_stretcher

Overview:
Per-lane converter from single-cycle pulses to level signals. It is the counterpart of the team's edge detector: it turns event pulses back into levels with a guaranteed minimum high time and a minimum low gap. A downstream synchroniser/edge detector (possibly in a slower domain) therefore sees exactly one clean rising edge per accepted event. Pulses that arrive while a lane is busy are queued one-deep, and dropped pulses are flagged.

Parameters:
WIDTH, 1, number of independent lanes
HIGH_CYCLES, 4, cycles level_out stays high per event (>=1)
GAP_CYCLES, 2, minimum low cycles after each high phase before the next high phase (>=1)

Ports:
clk  input  1  clock, all state on rising edge
async_nreset  input  1  reset, asynchronous, active-low
pulse_in  input  WIDTH  event pulses, one bit per lane, sampled every rising edge
level_out  output  WIDTH  registered stretched level per lane
busy  output  WIDTH  lane not IDLE or has pending event
overflow  output  WIDTH  registered 1-cycle flag: pulse dropped on that lane

Behaviour:
- Lanes are fully independent; all logic is replicated per bit. Describe one lane below.
- Per-lane state: FSM {IDLE, HIGH, GAP}, down-counter cnt of width $clog2(max(HIGH_CYCLES,GAP_CYCLES)), and a pending flag.
- Reset (async, immediate, also mid-operation): state=IDLE, cnt=0, pending=0, level_out=0, overflow=0. busy=0 as a consequence.
- IDLE: pulse_in=1 -> HIGH with cnt=HIGH_CYCLES-1. level_out rises in the next cycle (latency 1).
- HIGH: level_out=1. While cnt!=0, cnt decrements. At cnt==0 -> GAP with cnt=GAP_CYCLES-1.
- GAP: level_out=0. While cnt!=0, cnt decrements. At cnt==0, if pending=1 or pulse_in=1 -> HIGH with cnt=HIGH_CYCLES-1, else -> IDLE.
- level_out is a flop equal to (next_state==HIGH). It has no combinational path from pulse_in.
- High phase lasts exactly HIGH_CYCLES cycles. Low phase between two high phases lasts exactly GAP_CYCLES cycles when an event is queued.
- Pending, non-retrigger build:
  - A pulse accepted in HIGH or GAP that does not start a high phase itself sets pending.
  - "consume" = GAP end with pending=1 (pending launches the new high phase).
  - pending_next = (pending & ~consume) | accepted_pulse.
  - A pulse in the same cycle as consume re-sets pending; it is not dropped.
- Drop: pulse_in=1 while pending=1 and no consume that cycle. The pulse is discarded and overflow=1 for the following cycle only.
- A pulse in the final GAP cycle with pending=0 starts HIGH directly; pending stays 0.
- busy = (state!=IDLE) | pending, decoded from registers.
- No counter wrap: cnt only loads or decrements while nonzero.

Optional Feature:
Macro PULSE_STRETCHER_RETRIGGER_EN.
- Defined: pulse_in=1 in HIGH reloads cnt=HIGH_CYCLES-1, extending the high phase. It never sets pending. Pulses in GAP behave as in the base build.
- Undefined: pulses in HIGH follow the pending/drop rules above.

Test Plan:
Cycle n means "pulse_in high during cycle n". Parameters for these tests: HIGH_CYCLES=3, GAP_CYCLES=2, WIDTH=2.
- Single pulse lane0 cycle 10 -> level_out[0]=1 cycles 11..13, 0 from 14. busy[0]=1 cycles 11..15. Lane1 stays 0.
- Pulses cycle 10 and 12, no retrigger -> high 11..13, low 14..15, high 16..18. overflow stays 0.
- Same stimulus with PULSE_STRETCHER_RETRIGGER_EN -> high 11..15 continuous, low 16..17, IDLE cycle 18.
- Pulses cycles 10, 12, 14, no retrigger -> overflow[0]=1 in cycle 15 only. Exactly two high phases: 11..13 and 16..18.
- Pulses in cycles 10 and 15 (final GAP cycle) -> high 11..13 and 16..18. pending never set.
- async_nreset low in cycle 12 while lane1 HIGH -> level_out, busy, overflow drop to 0 immediately. After release, a pulse in cycle 20 gives high 21..23.
